// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding muxes and a saturating bubble counter.
// Optional macro ID_EX_FORWARD_EN enables hazard-unit forwarding; without it operands come straight from the register.
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_ex,
    input  logic [1:0]       forward_a,
    input  logic [1:0]       forward_b,
    input  logic [31:0]      rd1_id,
    input  logic [31:0]      rd2_id,
    input  logic [31:0]      sign_imm_id,
    input  logic [4:0]       rs_id,
    input  logic [4:0]       rt_id,
    input  logic [4:0]       rd_id,
    input  logic             cu_reg_write_id,
    input  logic             cu_mem_to_reg_id,
    input  logic             cu_mem_write_id,
    input  logic             cu_alu_src_id,
    input  logic             cu_reg_dst_id,
    input  logic [2:0]       cu_alu_control_id,
    input  logic [31:0]      alu_result_mem,
    input  logic [31:0]      result_wb,
    output logic [4:0]       rs_ex,
    output logic [4:0]       rt_ex,
    output logic             cu_reg_write_ex,
    output logic             cu_mem_to_reg_ex,
    output logic             cu_mem_write_ex,
    output logic [2:0]       cu_alu_control_ex,
    output logic [31:0]      src_a_ex,
    output logic [31:0]      src_b_ex,
    output logic [31:0]      write_data_ex,
    output logic [4:0]       write_reg_ex,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_write;
        logic        alu_src;
        logic        reg_dst;
        logic [2:0]  alu_control;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
    } ex_regs_t;

    ex_regs_t         regs_q, regs_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0]      fwd_a, fwd_b;

    // A flush turns the slot into an all-zero bubble, which is a harmless NOP.
    always_comb begin
        regs_d       = '0;
        bubble_cnt_d = bubble_cnt_q;
        if (flush_ex) begin
            if (bubble_cnt_q != {CNT_W{1'b1}}) begin
                bubble_cnt_d = bubble_cnt_q + 1'b1;
            end
        end else begin
            regs_d.reg_write   = cu_reg_write_id;
            regs_d.mem_to_reg  = cu_mem_to_reg_id;
            regs_d.mem_write   = cu_mem_write_id;
            regs_d.alu_src     = cu_alu_src_id;
            regs_d.reg_dst     = cu_reg_dst_id;
            regs_d.alu_control = cu_alu_control_id;
            regs_d.rs          = rs_id;
            regs_d.rt          = rt_id;
            regs_d.rd          = rd_id;
            regs_d.rd1         = rd1_id;
            regs_d.rd2         = rd2_id;
            regs_d.imm         = sign_imm_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q       <= '0;
            bubble_cnt_q <= '0;
        end else begin
            regs_q       <= regs_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

`ifdef ID_EX_FORWARD_EN
    function automatic logic [31:0] fwd_sel(input logic [1:0]  sel,
                                            input logic [31:0] reg_val,
                                            input logic [31:0] mem_val,
                                            input logic [31:0] wb_val);
        case (sel)
            2'b01:   return wb_val;
            2'b10:   return mem_val;
            default: return reg_val;
        endcase
    endfunction

    assign fwd_a = fwd_sel(forward_a, regs_q.rd1, alu_result_mem, result_wb);
    assign fwd_b = fwd_sel(forward_b, regs_q.rd2, alu_result_mem, result_wb);
`else
    // Hazards are resolved by scheduled NOPs, so the forwarding inputs are dropped.
    logic unused_fwd;
    assign unused_fwd = ^{forward_a, forward_b, alu_result_mem, result_wb};
    assign fwd_a      = regs_q.rd1;
    assign fwd_b      = regs_q.rd2;
`endif

    assign rs_ex             = regs_q.rs;
    assign rt_ex             = regs_q.rt;
    assign cu_reg_write_ex   = regs_q.reg_write;
    assign cu_mem_to_reg_ex  = regs_q.mem_to_reg;
    assign cu_mem_write_ex   = regs_q.mem_write;
    assign cu_alu_control_ex = regs_q.alu_control;
    assign src_a_ex          = fwd_a;
    assign write_data_ex     = fwd_b;
    assign src_b_ex          = regs_q.alu_src ? regs_q.imm : fwd_b;
    assign write_reg_ex      = regs_q.reg_dst ? regs_q.rd : regs_q.rt;
    assign bubble_cnt        = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, hand sequences and a randomized run against a model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_ex;
    logic [1:0]  forward_a, forward_b;
    logic [31:0] rd1_id, rd2_id, sign_imm_id;
    logic [4:0]  rs_id, rt_id, rd_id;
    logic        cu_reg_write_id, cu_mem_to_reg_id, cu_mem_write_id, cu_alu_src_id, cu_reg_dst_id;
    logic [2:0]  cu_alu_control_id;
    logic [31:0] alu_result_mem, result_wb;

    logic [4:0]  rs_ex, rt_ex, write_reg_ex;
    logic        cu_reg_write_ex, cu_mem_to_reg_ex, cu_mem_write_ex;
    logic [2:0]  cu_alu_control_ex;
    logic [31:0] src_a_ex, src_b_ex, write_data_ex;
    logic [15:0] bubble_cnt;

    logic [4:0]  s_rs_ex, s_rt_ex, s_write_reg_ex;
    logic        s_rw_ex, s_m2r_ex, s_mw_ex;
    logic [2:0]  s_alu_ex;
    logic [31:0] s_src_a_ex, s_src_b_ex, s_wd_ex;
    logic [3:0]  s_bubble_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush_ex(flush_ex),
        .forward_a(forward_a), .forward_b(forward_b),
        .rd1_id(rd1_id), .rd2_id(rd2_id), .sign_imm_id(sign_imm_id),
        .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
        .cu_reg_write_id(cu_reg_write_id), .cu_mem_to_reg_id(cu_mem_to_reg_id),
        .cu_mem_write_id(cu_mem_write_id), .cu_alu_src_id(cu_alu_src_id),
        .cu_reg_dst_id(cu_reg_dst_id), .cu_alu_control_id(cu_alu_control_id),
        .alu_result_mem(alu_result_mem), .result_wb(result_wb),
        .rs_ex(rs_ex), .rt_ex(rt_ex),
        .cu_reg_write_ex(cu_reg_write_ex), .cu_mem_to_reg_ex(cu_mem_to_reg_ex),
        .cu_mem_write_ex(cu_mem_write_ex), .cu_alu_control_ex(cu_alu_control_ex),
        .src_a_ex(src_a_ex), .src_b_ex(src_b_ex), .write_data_ex(write_data_ex),
        .write_reg_ex(write_reg_ex), .bubble_cnt(bubble_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, used for saturation.
    id_ex_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush_ex(flush_ex),
        .forward_a(forward_a), .forward_b(forward_b),
        .rd1_id(rd1_id), .rd2_id(rd2_id), .sign_imm_id(sign_imm_id),
        .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
        .cu_reg_write_id(cu_reg_write_id), .cu_mem_to_reg_id(cu_mem_to_reg_id),
        .cu_mem_write_id(cu_mem_write_id), .cu_alu_src_id(cu_alu_src_id),
        .cu_reg_dst_id(cu_reg_dst_id), .cu_alu_control_id(cu_alu_control_id),
        .alu_result_mem(alu_result_mem), .result_wb(result_wb),
        .rs_ex(s_rs_ex), .rt_ex(s_rt_ex),
        .cu_reg_write_ex(s_rw_ex), .cu_mem_to_reg_ex(s_m2r_ex),
        .cu_mem_write_ex(s_mw_ex), .cu_alu_control_ex(s_alu_ex),
        .src_a_ex(s_src_a_ex), .src_b_ex(s_src_b_ex), .write_data_ex(s_wd_ex),
        .write_reg_ex(s_write_reg_ex), .bubble_cnt(s_bubble_cnt)
    );

    // Reference model: the instruction currently held in EX plus two bubble tallies.
    typedef struct {
        bit        rw, m2r, mw, asrc, rdst;
        bit [2:0]  alu;
        bit [4:0]  rs, rt, rd;
        bit [31:0] r1, r2, imm;
    } instr_t;

    instr_t m_ex;
    int     m_cnt16, m_cnt4;

    function automatic bit [31:0] pick(input bit [1:0] sel, input bit [31:0] regv);
`ifdef ID_EX_FORWARD_EN
        if (sel == 2'd1) return result_wb;
        if (sel == 2'd2) return alu_result_mem;
`endif
        return regv;
    endfunction

    task automatic model_reset();
        m_ex    = '{default: 0};
        m_cnt16 = 0;
        m_cnt4  = 0;
    endtask

    task automatic model_clock();
        if (flush_ex) begin
            m_ex    = '{default: 0};
            m_cnt16 = (m_cnt16 < 65535) ? m_cnt16 + 1 : 65535;
            m_cnt4  = (m_cnt4 < 15) ? m_cnt4 + 1 : 15;
        end else begin
            m_ex.rw = cu_reg_write_id; m_ex.m2r = cu_mem_to_reg_id; m_ex.mw = cu_mem_write_id;
            m_ex.asrc = cu_alu_src_id; m_ex.rdst = cu_reg_dst_id; m_ex.alu = cu_alu_control_id;
            m_ex.rs = rs_id; m_ex.rt = rt_id; m_ex.rd = rd_id;
            m_ex.r1 = rd1_id; m_ex.r2 = rd2_id; m_ex.imm = sign_imm_id;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        bit [31:0] fb;
        fb = pick(forward_b, m_ex.r2);
        chk({tag, ".rs_ex"}, 32'(rs_ex), 32'(m_ex.rs));
        chk({tag, ".rt_ex"}, 32'(rt_ex), 32'(m_ex.rt));
        chk({tag, ".reg_write"}, 32'(cu_reg_write_ex), 32'(m_ex.rw));
        chk({tag, ".mem_to_reg"}, 32'(cu_mem_to_reg_ex), 32'(m_ex.m2r));
        chk({tag, ".mem_write"}, 32'(cu_mem_write_ex), 32'(m_ex.mw));
        chk({tag, ".alu_ctl"}, 32'(cu_alu_control_ex), 32'(m_ex.alu));
        chk({tag, ".src_a"}, src_a_ex, pick(forward_a, m_ex.r1));
        chk({tag, ".write_data"}, write_data_ex, fb);
        chk({tag, ".src_b"}, src_b_ex, m_ex.asrc ? m_ex.imm : fb);
        chk({tag, ".write_reg"}, 32'(write_reg_ex), 32'(m_ex.rdst ? m_ex.rd : m_ex.rt));
        chk({tag, ".bubble_cnt"}, 32'(bubble_cnt), 32'(m_cnt16));
        chk({tag, ".bubble_cnt4"}, 32'(s_bubble_cnt), 32'(m_cnt4));
    endtask

    task automatic clear_inputs();
        flush_ex = 0; forward_a = 0; forward_b = 0;
        rd1_id = 0; rd2_id = 0; sign_imm_id = 0; rs_id = 0; rt_id = 0; rd_id = 0;
        cu_reg_write_id = 0; cu_mem_to_reg_id = 0; cu_mem_write_id = 0;
        cu_alu_src_id = 0; cu_reg_dst_id = 0; cu_alu_control_id = 0;
        alu_result_mem = 0; result_wb = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    typedef struct {
        string       name;
        bit          flush, m2r, asrc, rdst;
        bit [1:0]    fa, fb;
        bit [31:0]   rd1, rd2, imm, mem, wb;
        bit [4:0]    rt, rd;
        bit [31:0]   e_src_a, e_src_b, e_wd;
        bit [4:0]    e_wreg, e_rt;
        bit          e_m2r;
        int          e_cnt;
    } vec_t;

    vec_t vecs[5];
    bit   fwd_on;

    initial begin
`ifdef ID_EX_FORWARD_EN
        fwd_on = 1;
`else
        fwd_on = 0;
`endif
        // Hand-derived expectations for the directed scenarios.
        vecs[0] = '{"capture", 0, 0, 0, 0, 2'd0, 2'd0, 32'h11, 32'h22, 32'h0, 32'h0, 32'h0, 5'd5, 5'd9,
                    32'h11, 32'h22, 32'h22, 5'd5, 5'd5, 0, 0};
        vecs[1] = '{"fwd_mem_wb", 0, 0, 0, 1, 2'd2, 2'd1, 32'h1234, 32'h5678, 32'h0, 32'hAAAA0000, 32'h5555, 5'd3, 5'd7,
                    fwd_on ? 32'hAAAA0000 : 32'h1234, fwd_on ? 32'h5555 : 32'h5678, fwd_on ? 32'h5555 : 32'h5678,
                    5'd7, 5'd3, 0, 0};
        vecs[2] = '{"fwd_11_reg", 0, 0, 0, 0, 2'd3, 2'd0, 32'hCAFE, 32'hBEEF, 32'h0, 32'hAAAA0000, 32'h5555, 5'd4, 5'd6,
                    32'hCAFE, 32'hBEEF, 32'hBEEF, 5'd4, 5'd4, 0, 0};
        vecs[3] = '{"flush_load", 1, 1, 0, 0, 2'd0, 2'd0, 32'h99, 32'h88, 32'h0, 32'h0, 32'h0, 5'd8, 5'd2,
                    32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 0, 1};
        vecs[4] = '{"imm_fwd_b", 0, 0, 1, 0, 2'd0, 2'd2, 32'h1, 32'h77, 32'hFFFFFFFC, 32'h13579BDF, 32'h0, 5'd10, 5'd11,
                    32'h1, 32'hFFFFFFFC, fwd_on ? 32'h13579BDF : 32'h77, 5'd10, 5'd10, 0, 1};

        clear_inputs();
        rst_n = 0;
        model_reset();
        #3;
        chk("reset.src_a", src_a_ex, 32'h0);
        chk("reset.write_reg", 32'(write_reg_ex), 32'h0);
        chk("reset.rt_ex", 32'(rt_ex), 32'h0);
        chk("reset.bubble_cnt", 32'(bubble_cnt), 32'h0);
        chk("reset.reg_write", 32'(cu_reg_write_ex), 32'h0);
        #9 rst_n = 1;

        foreach (vecs[i]) begin
            clear_inputs();
            flush_ex = vecs[i].flush; cu_mem_to_reg_id = vecs[i].m2r;
            cu_reg_write_id = vecs[i].m2r;
            cu_alu_src_id = vecs[i].asrc; cu_reg_dst_id = vecs[i].rdst;
            forward_a = vecs[i].fa; forward_b = vecs[i].fb;
            rd1_id = vecs[i].rd1; rd2_id = vecs[i].rd2; sign_imm_id = vecs[i].imm;
            alu_result_mem = vecs[i].mem; result_wb = vecs[i].wb;
            rt_id = vecs[i].rt; rd_id = vecs[i].rd; rs_id = 5'd1;
            tick();
            chk({vecs[i].name, ".src_a"}, src_a_ex, vecs[i].e_src_a);
            chk({vecs[i].name, ".src_b"}, src_b_ex, vecs[i].e_src_b);
            chk({vecs[i].name, ".write_data"}, write_data_ex, vecs[i].e_wd);
            chk({vecs[i].name, ".write_reg"}, 32'(write_reg_ex), 32'(vecs[i].e_wreg));
            chk({vecs[i].name, ".rt_ex"}, 32'(rt_ex), 32'(vecs[i].e_rt));
            chk({vecs[i].name, ".mem_to_reg"}, 32'(cu_mem_to_reg_ex), 32'(vecs[i].e_m2r));
            chk({vecs[i].name, ".bubble_cnt"}, 32'(bubble_cnt), 32'(vecs[i].e_cnt));
        end

        // Saturation: 20 back-to-back flushes; narrow counter must park at 15.
        clear_inputs();
        flush_ex = 1;
        for (int c = 0; c < 20; c++) tick();
        chk("sat.bubble_cnt4", 32'(s_bubble_cnt), 32'd15);
        chk("sat.bubble_cnt16", 32'(bubble_cnt), 32'd21);
        check_model("sat");

        // Asynchronous reset between edges discards a live instruction.
        clear_inputs();
        rd1_id = 32'hDEAD0001; rd2_id = 32'hDEAD0002; rt_id = 5'd12; rs_id = 5'd13;
        cu_reg_write_id = 1; cu_mem_to_reg_id = 1;
        tick();
        check_model("pre_areset");
        forward_a = 2'd2; alu_result_mem = 32'h0BADF00D;
        #2 rst_n = 0;
        model_reset();
        #1;
        chk("areset.src_a_fa10", src_a_ex, fwd_on ? 32'h0BADF00D : 32'h0);
        chk("areset.rt_ex", 32'(rt_ex), 32'h0);
        chk("areset.mem_to_reg", 32'(cu_mem_to_reg_ex), 32'h0);
        chk("areset.bubble_cnt", 32'(bubble_cnt), 32'h0);
        chk("areset.bubble_cnt4", 32'(s_bubble_cnt), 32'h0);
        #1 rst_n = 1;
        tick();
        check_model("post_areset");

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            flush_ex = ($urandom_range(0, 3) == 0);
            forward_a = 2'($urandom); forward_b = 2'($urandom);
            rd1_id = $urandom; rd2_id = $urandom; sign_imm_id = $urandom;
            rs_id = 5'($urandom); rt_id = 5'($urandom); rd_id = 5'($urandom);
            cu_reg_write_id = 1'($urandom); cu_mem_to_reg_id = 1'($urandom);
            cu_mem_write_id = 1'($urandom); cu_alu_src_id = 1'($urandom);
            cu_reg_dst_id = 1'($urandom); cu_alu_control_id = 3'($urandom);
            alu_result_mem = $urandom; result_wb = $urandom;
            tick();
            check_model("rand");
            forward_a = 2'($urandom); forward_b = 2'($urandom);
            alu_result_mem = $urandom; result_wb = $urandom;
            #1;
            check_model("rand_comb");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
